// File: rtl/bus_a_src_sel_if.sv
// bus_a_src_sel_if: operand-select request side and buffered bus-A side of the source selector.
interface bus_a_src_sel_if #(
   parameter int WIDTH = 8,
   parameter int N_SRC = 4,
   parameter int SEL_W = 4
);
   logic [N_SRC*WIDTH-1:0] src_flat;
   logic [SEL_W-1:0]       sel;
   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH-1:0]       bus_a;
   logic [SEL_W-1:0]       bus_a_sel;
   logic                   out_valid;
   logic                   out_ready;
   logic                   sel_err;
   logic                   clr_err;

   modport master (
      output src_flat, sel, in_valid, out_ready, clr_err,
      input  in_ready, bus_a, bus_a_sel, out_valid, sel_err
   );
   modport slave (
      input  src_flat, sel, in_valid, out_ready, clr_err,
      output in_ready, bus_a, bus_a_sel, out_valid, sel_err
   );
endinterface

// File: rtl/bus_a_src_sel.sv
// bus_a_src_sel: picks one of N_SRC operand sources and queues it in a 2-entry elastic buffer.
module bus_a_src_sel #(
   parameter int WIDTH = 8,
   parameter int N_SRC = 4,
   parameter int SEL_W = 4
) (
   input logic             clk,
   input logic             rst_n,
   bus_a_src_sel_if.slave  bus
);
   logic [WIDTH-1:0] r_d0, r_d1;
   logic [SEL_W-1:0] r_s0, r_s1;
   logic [1:0]       r_cnt;
   logic             r_err;
   logic             w_push, w_pop, w_bad;
   logic [WIDTH-1:0] w_data;

   assign bus.in_ready  = r_cnt != 2'd2;
   assign bus.out_valid = r_cnt != 2'd0;
   assign bus.bus_a     = bus.out_valid ? r_d0 : '0;
   assign bus.bus_a_sel = bus.out_valid ? r_s0 : '0;
   assign bus.sel_err   = r_err;
   assign w_push = bus.in_valid & bus.in_ready;
   assign w_pop  = bus.out_valid & bus.out_ready;
   assign w_bad  = int'(bus.sel) >= N_SRC;

   // Out-of-range selects match no source and leave the captured data at zero.
   always_comb begin
      w_data = '0;
      for (int k = 0; k < N_SRC; k++)
         if (int'(bus.sel) == k) w_data = bus.src_flat[k*WIDTH +: WIDTH];
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_d0  <= '0;
         r_d1  <= '0;
         r_s0  <= '0;
         r_s1  <= '0;
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_push && (r_cnt == 2'd0 || (r_cnt == 2'd1 && w_pop))) begin
            r_d0 <= w_data;
            r_s0 <= bus.sel;
         end else if (w_pop) begin
            r_d0 <= r_d1;
            r_s0 <= r_s1;
         end
         if (w_push && r_cnt == 2'd1 && !w_pop) begin
            r_d1 <= w_data;
            r_s1 <= bus.sel;
         end
         r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
         r_err <= (w_push & w_bad) | (r_err & ~bus.clr_err);
      end
endmodule

// File: tb/tb_bus_a_src_sel.sv
// tb_bus_a_src_sel: directed checks on an 8-bit/4-source instance and a scoreboarded 16-bit/8-source instance.
module tb_bus_a_src_sel;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_run = 0, n_fail = 0;

   always #5 clk = ~clk;

   bus_a_src_sel_if #(.WIDTH(8),  .N_SRC(4), .SEL_W(4)) ia();
   bus_a_src_sel_if #(.WIDTH(16), .N_SRC(8), .SEL_W(3)) ib();

   bus_a_src_sel #(.WIDTH(8),  .N_SRC(4), .SEL_W(4)) da(.clk(clk), .rst_n(rst_n), .bus(ia.slave));
   bus_a_src_sel #(.WIDTH(16), .N_SRC(8), .SEL_W(3)) db(.clk(clk), .rst_n(rst_n), .bus(ib.slave));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0]   s8 [4] = '{8'h03, 8'hA5, 8'h7F, 8'hC3};
   logic [15:0]  s16 [8];
   logic [127:0] flat16;
   logic [15:0]  q_d[$];
   logic [2:0]   q_s[$];
   logic         push, pop;

   initial begin
      ia.src_flat = {8'hC3, 8'h7F, 8'hA5, 8'h03};
      ia.sel = '0; ia.in_valid = 0; ia.out_ready = 0; ia.clr_err = 0;
      ib.src_flat = '0;
      ib.sel = '0; ib.in_valid = 0; ib.out_ready = 0; ib.clr_err = 0;
      tick();
      // 1: reset state, single push
      chk("rst_valid", ia.out_valid, 0);
      chk("rst_bus_a", ia.bus_a, 0);
      chk("rst_in_ready", ia.in_ready, 1);
      chk("rst_sel_err", ia.sel_err, 0);
      rst_n = 1;
      tick();
      ia.sel = 1; ia.in_valid = 1;
      tick();
      ia.in_valid = 0;
      chk("t1_valid", ia.out_valid, 1);
      chk("t1_bus_a", ia.bus_a, 8'hA5);
      chk("t1_sel", ia.bus_a_sel, 1);
      ia.out_ready = 1;
      tick();
      ia.out_ready = 0;
      chk("t1_empty", ia.out_valid, 0);
      chk("t1_empty_bus", ia.bus_a, 0);
      // 2: fill to two, third offer refused, drain in order
      ia.in_valid = 1; ia.sel = 0;
      tick();
      ia.sel = 2;
      tick();
      chk("t2_full", ia.in_ready, 0);
      chk("t2_head", ia.bus_a, 8'h03);
      ia.sel = 3;
      tick();
      chk("t2_hold", ia.bus_a, 8'h03);
      chk("t2_full2", ia.in_ready, 0);
      ia.in_valid = 0; ia.out_ready = 1;
      tick();
      chk("t2_second", ia.bus_a, 8'h7F);
      chk("t2_second_sel", ia.bus_a_sel, 2);
      chk("t2_ready", ia.in_ready, 1);
      tick();
      chk("t2_drained", ia.out_valid, 0);
      // 3: streaming push+pop at count 1
      ia.out_ready = 0; ia.in_valid = 1; ia.sel = 0;
      tick();
      ia.out_ready = 1;
      for (int i = 0; i < 20; i++) begin
         ia.sel = 4'(i % 4);
         tick();
         chk("t3_valid", ia.out_valid, 1);
         chk("t3_bus_a", ia.bus_a, 32'(s8[i % 4]));
      end
      ia.in_valid = 0;
      tick();
      chk("t3_drained", ia.out_valid, 0);
      // 4: out-of-range select and sticky error
      ia.in_valid = 1; ia.sel = 5;
      tick();
      chk("t4_bad_data", ia.bus_a, 0);
      chk("t4_bad_sel", ia.bus_a_sel, 5);
      chk("t4_bad_valid", ia.out_valid, 1);
      chk("t4_err", ia.sel_err, 1);
      ia.sel = 1; ia.clr_err = 1;
      tick();
      chk("t4_clr_good", ia.sel_err, 0);
      chk("t4_good_data", ia.bus_a, 8'hA5);
      ia.sel = 9;
      tick();
      chk("t4_set_wins", ia.sel_err, 1);
      chk("t4_bad_sel2", ia.bus_a_sel, 9);
      ia.clr_err = 0; ia.in_valid = 0;
      tick();
      chk("t4_sticky", ia.sel_err, 1);
      chk("t4_drained", ia.out_valid, 0);
      ia.clr_err = 1;
      tick();
      chk("t4_clr", ia.sel_err, 0);
      ia.clr_err = 0;
      // 5: async reset with two entries held
      ia.out_ready = 0; ia.in_valid = 1; ia.sel = 2;
      tick();
      tick();
      ia.in_valid = 0;
      chk("t5_full", ia.in_ready, 0);
      #2 rst_n = 0;
      #1;
      chk("t5_valid", ia.out_valid, 0);
      chk("t5_bus_a", ia.bus_a, 0);
      chk("t5_ready_rst", ia.in_ready, 1);
      tick();
      rst_n = 1;
      tick();
      chk("t5_ready", ia.in_ready, 1);
      chk("t5_empty", ia.out_valid, 0);
      // 6: wide instance, directed first then random with scoreboard
      for (int k = 0; k < 8; k++) begin
         s16[k] = 16'($urandom);
         flat16[k*16 +: 16] = s16[k];
      end
      ib.src_flat = flat16;
      chk("t6_rst_valid", ib.out_valid, 0);
      ib.sel = 1; ib.in_valid = 1;
      tick();
      ib.in_valid = 0;
      chk("t6_bus_a", ib.bus_a, 32'(s16[1]));
      chk("t6_sel", ib.bus_a_sel, 1);
      ib.out_ready = 1;
      tick();
      chk("t6_empty", ib.out_valid, 0);
      for (int c = 0; c < 300; c++) begin
         for (int k = 0; k < 8; k++) begin
            s16[k] = 16'($urandom);
            flat16[k*16 +: 16] = s16[k];
         end
         ib.src_flat = flat16;
         ib.sel = 3'($urandom_range(0, 7));
         ib.in_valid = 1'($urandom_range(0, 1));
         ib.out_ready = ($urandom_range(0, 3) != 0);
         #1;
         chk("t6_ready", ib.in_ready, 32'(q_d.size() != 2));
         chk("t6_valid", ib.out_valid, 32'(q_d.size() != 0));
         push = ib.in_valid & (q_d.size() != 2);
         pop = ib.out_ready & (q_d.size() != 0);
         if (pop) begin
            chk("t6_order", ib.bus_a, 32'(q_d.pop_front()));
            chk("t6_order_sel", ib.bus_a_sel, 32'(q_s.pop_front()));
         end
         if (push) begin
            q_d.push_back(s16[ib.sel]);
            q_s.push_back(ib.sel);
         end
         @(posedge clk);
         #1;
      end
      chk("t6_no_err", ib.sel_err, 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
